// File: rtl/serial_frame_rx.sv
// Oversampled serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Every bit is sampled at mid-bit; the received word is presented with a one-cycle valid strobe.
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int OS        = 4,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sdata,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              par_err,
    output logic              busy
);
    localparam int LAST = OS/2 + OS*(DATA_W + 1 + PARITY_EN);
    localparam int CW   = $clog2(LAST + 2);
    localparam int BW   = $clog2(DATA_W + 3);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     tick;
    logic [CW-1:0]     samp;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sr;
    logic              par_bad;
    logic              hit;

    // tick is the index of the en tick being taken on this edge, counted from detection (tick 0)
    assign tick = cnt + CW'(1);

    always_comb begin
        samp = CW'(OS/2);
        if (state != START)
            samp = CW'(OS/2 + OS) + CW'(OS) * CW'(bit_cnt);
    end

    assign hit = (tick == samp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            par_bad   <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            busy      <= (state != IDLE);
            if (en) begin
                if (state == IDLE) begin
                    if (!sdata) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                        busy    <= 1'b1;
                    end
                end else begin
                    cnt <= tick;
                    if (hit) begin
                        case (state)
                            START: begin
                                if (sdata) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end else begin
                                    state   <= DATA;
                                    bit_cnt <= '0;
                                end
                            end
                            DATA: begin
                                sr      <= DATA_W'({sdata, sr} >> 1);
                                bit_cnt <= bit_cnt + BW'(1);
                                if (bit_cnt == BW'(DATA_W - 1))
                                    state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end
                            PARITY: begin
                                par_bad <= (^sr) ^ sdata;
                                bit_cnt <= bit_cnt + BW'(1);
                                state   <= STOP;
                            end
                            STOP: begin
                                // framing error wins over parity; data only moves on a clean frame
                                state <= IDLE;
                                busy  <= 1'b1;
                                if (!sdata)
                                    frame_err <= 1'b1;
                                else if (par_bad)
                                    par_err <= 1'b1;
                                else begin
                                    data  <= sr;
                                    valid <= 1'b1;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end
        end
    end
endmodule
